// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one word fetch at a time on a
// req/gnt/rvalid bus and hands registered instructions to decode.
//
//  state  | meaning
//  S_REQ  | request pending on the bus (suppressed while the hold buffer is full)
//  S_WAIT | granted request outstanding, waiting for rvalid
//  S_DROP | outstanding request is wrong-path after a jal; discard its data
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          ADDR_W   = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_gnt,
   input  logic              imem_rvalid,
   input  logic [31:0]       imem_rdata,
   output logic              id_valid,
   input  logic              id_ready,
   output logic [31:0]       id_instr,
   output logic [5:0]        id_opcode,
   output logic [5:0]        id_func,
   output logic [ADDR_W-1:0] id_pc_plus4,
   input  logic              redirect,
   input  logic [25:0]       redirect_target
);

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] req_pc_q, req_pc_d;
   logic              or_valid_q, or_valid_d;
   logic [31:0]       or_instr_q, or_instr_d;
   logic [ADDR_W-1:0] or_pc4_q, or_pc4_d;
   logic              hb_valid_q, hb_valid_d;
   logic [31:0]       hb_instr_q, hb_instr_d;
   logic [ADDR_W-1:0] hb_pc4_q, hb_pc4_d;

   logic consume, redir, req_fire;

   // Request is forced low during reset so the bus sees nothing until release.
   assign imem_req    = rst_n & (state_q == S_REQ) & ~hb_valid_q;
   assign imem_addr   = pc_q;
   assign id_valid    = or_valid_q;
   assign id_instr    = or_instr_q;
   assign id_opcode   = or_instr_q[31:26];
   assign id_func     = or_instr_q[5:0];
   assign id_pc_plus4 = or_pc4_q;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      req_pc_d   = req_pc_q;
      or_valid_d = or_valid_q;
      or_instr_d = or_instr_q;
      or_pc4_d   = or_pc4_q;
      hb_valid_d = hb_valid_q;
      hb_instr_d = hb_instr_q;
      hb_pc4_d   = hb_pc4_q;

      consume  = or_valid_q & id_ready;
      redir    = consume & redirect;
      req_fire = imem_req & imem_gnt;

      if (consume) begin
         if (hb_valid_q) begin
            or_instr_d = hb_instr_q;
            or_pc4_d   = hb_pc4_q;
            hb_valid_d = 1'b0;
         end else begin
            or_valid_d = 1'b0;
         end
      end

      case (state_q)
         S_REQ: begin
            if (req_fire) begin
               req_pc_d = pc_q;
               pc_d     = pc_q + ADDR_W'(4);
               state_d  = redir ? S_DROP : S_WAIT;
            end
         end
         S_WAIT: begin
            if (imem_rvalid) begin
               state_d = S_REQ;
               // The hold buffer is always empty here: it only fills on the
               // way back to S_REQ, which then stalls until it drains.
               if (!redir) begin
                  if (!or_valid_q || consume) begin
                     or_valid_d = 1'b1;
                     or_instr_d = imem_rdata;
                     or_pc4_d   = req_pc_q + ADDR_W'(4);
                  end else begin
                     hb_valid_d = 1'b1;
                     hb_instr_d = imem_rdata;
                     hb_pc4_d   = req_pc_q + ADDR_W'(4);
                  end
               end
            end else if (redir) begin
               state_d = S_DROP;
            end
         end
         S_DROP: begin
            if (imem_rvalid) state_d = S_REQ;
         end
         default: state_d = S_REQ;
      endcase

      if (redir) begin
         pc_d       = {or_pc4_q[ADDR_W-1:ADDR_W-4], redirect_target, 2'b00};
         or_valid_d = 1'b0;
         hb_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_REQ;
         pc_q       <= RESET_PC;
         req_pc_q   <= '0;
         or_valid_q <= 1'b0;
         or_instr_q <= '0;
         or_pc4_q   <= '0;
         hb_valid_q <= 1'b0;
         hb_instr_q <= '0;
         hb_pc4_q   <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         req_pc_q   <= req_pc_d;
         or_valid_q <= or_valid_d;
         or_instr_q <= or_instr_d;
         or_pc4_q   <= or_pc4_d;
         hb_valid_q <= hb_valid_d;
         hb_instr_q <= hb_instr_d;
         hb_pc4_q   <= hb_pc4_d;
      end
   end

endmodule
